// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing 16 x 8-bit registers; bus writes pulse wr_strobe.
// Ports: clk/rst_n, scl/sda pads, busy, wr_strobe/addr/data, rd_addr/data.
module i2c_slave_regfile #(
  parameter logic [7:0] DEV_ADDR = 8'h72
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic       busy,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_DEV_ACK,
    S_REG_ADDR,
    S_REG_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK
  } state_t;

  state_t state, state_n;

  logic scl_s1, scl_s, scl_d;
  logic sda_s1, sda_s, sda_d;

  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [3:0] ptr, ptr_n;
  logic       oe_n, busy_n, strobe_n;
  logic [3:0] waddr_n;
  logic [7:0] wdata_n;
  logic [7:0] regs [16];

  logic scl_rise, scl_fall, start, stop;
  logic [7:0] rx_byte, cur_reg;

  assign sda_pad_o = 1'b0;
  assign rd_data   = regs[rd_addr];
  assign cur_reg   = regs[ptr];
  assign rx_byte   = {shreg[6:0], sda_s};

  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s  <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_pad_i;
      scl_s  <= scl_s1;
      scl_d  <= scl_s;
      sda_s1 <= sda_pad_i;
      sda_s  <= sda_s1;
      sda_d  <= sda_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bit_cnt      <= 4'd0;
      shreg        <= 8'h00;
      ptr          <= 4'd0;
      sda_padoen_o <= 1'b1;
      busy         <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_addr      <= 4'd0;
      wr_data      <= 8'h00;
      for (int i = 0; i < 16; i++)
        regs[i] <= 8'h00;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      shreg        <= shreg_n;
      ptr          <= ptr_n;
      sda_padoen_o <= oe_n;
      busy         <= busy_n;
      wr_strobe    <= strobe_n;
      wr_addr      <= waddr_n;
      wr_data      <= wdata_n;
      if (strobe_n)
        regs[waddr_n] <= wdata_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    oe_n      = sda_padoen_o;
    busy_n    = busy;
    strobe_n  = 1'b0;
    waddr_n   = wr_addr;
    wdata_n   = wr_data;
    if (start) begin
      state_n   = S_DEV_ADDR;
      bit_cnt_n = 4'd0;
      oe_n      = 1'b1;
    end else if (stop) begin
      state_n = S_IDLE;
      oe_n    = 1'b1;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          oe_n = 1'b1;
        end
        S_DEV_ADDR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shreg[7:1] == DEV_ADDR[7:1]) begin
              state_n = S_DEV_ACK;
              oe_n    = 1'b0;
              busy_n  = 1'b1;
            end else begin
              state_n = S_IDLE;
              busy_n  = 1'b0;
            end
          end
        end
        S_DEV_ACK: begin
          // shreg[0] still holds the R/W bit here
          if (scl_fall) begin
            bit_cnt_n = 4'd0;
            if (shreg[0]) begin
              state_n = S_RD_DATA;
              shreg_n = cur_reg;
              oe_n    = cur_reg[7];
            end else begin
              state_n = S_REG_ADDR;
              oe_n    = 1'b1;
            end
          end
        end
        S_REG_ADDR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7)
              ptr_n = rx_byte[3:0];
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_n = S_REG_ACK;
            oe_n    = 1'b0;
          end
        end
        S_WR_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              strobe_n = 1'b1;
              waddr_n  = ptr;
              wdata_n  = rx_byte;
              ptr_n    = ptr + 4'd1;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_n = S_WR_ACK;
            oe_n    = 1'b0;
          end
        end
        S_REG_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            state_n   = S_WR_DATA;
            bit_cnt_n = 4'd0;
            oe_n      = 1'b1;
          end
        end
        S_RD_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_n = S_RD_ACK;
            oe_n    = 1'b1;
            ptr_n   = ptr + 4'd1;
          end else if (scl_fall) begin
            shreg_n = {shreg[6:0], 1'b0};
            oe_n    = shreg[6];
          end
        end
        S_RD_ACK: begin
          // master's ACK/NACK is parked in shreg[0]
          if (scl_rise) begin
            shreg_n = {shreg[7:1], sda_s};
          end else if (scl_fall) begin
            if (!shreg[0]) begin
              state_n   = S_RD_DATA;
              bit_cnt_n = 4'd0;
              shreg_n   = cur_reg;
              oe_n      = cur_reg[7];
            end else begin
              state_n = S_IDLE;
              oe_n    = 1'b1;
              busy_n  = 1'b0;
            end
          end
        end
        default: begin
          state_n = S_IDLE;
          oe_n    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-level I2C master, register model,
// strobe scoreboard, vector table, corner sequences and random traffic.
module tb_i2c_slave_regfile;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       sda_pad_o;
  logic       sda_padoen_o;
  logic       busy;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model [16];
  logic [3:0] ptr_m;
  logic       busy_seen;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } sb_t;
  sb_t sq[$];

  typedef struct {
    logic [7:0] dev;
    logic [7:0] rb;
    logic [7:0] data;
    logic       exp_ack;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

  i2c_slave_regfile #(.DEV_ADDR(8'h72)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_pad_i    (scl),
    .sda_pad_i    (sda_line),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .busy         (busy),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  always @(negedge clk) begin
    if (wr_strobe) sq.push_back({wr_addr, wr_data});
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wclk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic peek(logic [3:0] a, logic [7:0] exp);
    rd_addr = a;
    #1;
    chk("rd_data", {24'h0, rd_data}, {24'h0, exp});
  endtask

  task automatic i2c_start;
    wclk(5); sda_m = 1'b1;
    wclk(5); scl = 1'b1;
    wclk(10); sda_m = 1'b0;
    wclk(10); scl = 1'b0;
  endtask

  task automatic i2c_stop;
    wclk(5); sda_m = 1'b0;
    wclk(5); scl = 1'b1;
    wclk(10); sda_m = 1'b1;
    wclk(10);
  endtask

  task automatic send_bit(logic b);
    wclk(5); sda_m = b;
    wclk(5); scl = 1'b1;
    wclk(10); scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wclk(2); sda_m = 1'b1;
    wclk(8); scl = 1'b1;
    wclk(5); b = sda_line;
    wclk(5); scl = 1'b0;
  endtask

  task automatic write_byte(logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(~mack);
  endtask

  task automatic do_write(logic [7:0] rb, int n, logic [23:0] d);
    logic       ack;
    logic [7:0] db;
    logic [3:0] ri;
    sq.delete();
    i2c_start;
    write_byte(8'h72, ack);
    chk("wr_dev_ack", {31'h0, ack}, 1);
    write_byte(rb, ack);
    chk("wr_reg_ack", {31'h0, ack}, 1);
    for (int i = 0; i < n; i++) begin
      db = d[23-8*i -: 8];
      write_byte(db, ack);
      chk("wr_data_ack", {31'h0, ack}, 1);
      ri = rb[3:0] + 4'(i);
      model[ri] = db;
    end
    i2c_stop;
    wclk(2);
    chk("wr_strobe_count", sq.size(), n);
    for (int i = 0; i < n && i < sq.size(); i++) begin
      ri = rb[3:0] + 4'(i);
      chk("wr_strobe_addr", {28'h0, sq[i].a}, {28'h0, ri});
      chk("wr_strobe_data", {24'h0, sq[i].d}, {24'h0, model[ri]});
    end
    chk("wr_busy_after_stop", {31'h0, busy}, 0);
    ptr_m = rb[3:0] + 4'(n);
  endtask

  task automatic read_tail(int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      read_byte(d, i != n - 1);
      chk("rd_byte", {24'h0, d}, {24'h0, model[ptr_m]});
      ptr_m = ptr_m + 4'd1;
    end
    wclk(6);
    chk("rd_sda_released", {31'h0, sda_padoen_o}, 1);
    chk("rd_busy_after_nack", {31'h0, busy}, 0);
    i2c_stop;
  endtask

  task automatic do_read(logic [3:0] r, int n);
    logic ack;
    i2c_start;
    write_byte(8'h72, ack);
    chk("rd_dev_ack", {31'h0, ack}, 1);
    write_byte({4'h0, r}, ack);
    chk("rd_reg_ack", {31'h0, ack}, 1);
    ptr_m = r;
    i2c_start;
    write_byte(8'h73, ack);
    chk("rd_dev73_ack", {31'h0, ack}, 1);
    chk("rd_busy", {31'h0, busy}, 1);
    read_tail(n);
  endtask

  initial begin
    logic ack;
    vecs[0] = '{8'h72, 8'h08, 8'h35, 1'b1};
    vecs[1] = '{8'h7A, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{8'h72, 8'h00, 8'h5A, 1'b1};
    vecs[3] = '{8'h70, 8'h01, 8'h11, 1'b0};
    vecs[4] = '{8'hF2, 8'h01, 8'h22, 1'b0};
    vecs[5] = '{8'h72, 8'h9C, 8'hC3, 1'b1};
    vecs[6] = '{8'h72, 8'h0F, 8'hFF, 1'b1};
    vecs[7] = '{8'h32, 8'h02, 8'h33, 1'b0};

    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    ptr_m = 4'd0;
    rst_n = 1'b0;
    scl = 1'b1;
    sda_m = 1'b1;
    rd_addr = 4'd0;
    wclk(4);
    chk("rst_oe", {31'h0, sda_padoen_o}, 1);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_strobe", {31'h0, wr_strobe}, 0);
    chk("rst_waddr", {28'h0, wr_addr}, 0);
    chk("rst_wdata", {24'h0, wr_data}, 0);
    chk("sda_pad_o", {31'h0, sda_pad_o}, 0);
    peek(4'd0, 8'h00);
    peek(4'd9, 8'h00);
    rst_n = 1'b1;
    wclk(4);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].exp_ack) begin
        do_write(vecs[v].rb, 1, {vecs[v].data, 16'h0});
        peek(vecs[v].rb[3:0], vecs[v].data);
      end else begin
        sq.delete();
        busy_seen = 1'b0;
        i2c_start;
        write_byte(vecs[v].dev, ack);
        chk("nomatch_ack", {31'h0, ack}, 0);
        i2c_stop;
        wclk(2);
        chk("nomatch_busy", {31'h0, busy_seen}, 0);
        chk("nomatch_strobes", sq.size(), 0);
      end
    end

    do_write(8'h0F, 2, 24'hA1B200);
    peek(4'd15, 8'hA1);
    peek(4'd0, 8'hB2);

    // ptr persists: plain read continues at the index after the last write
    i2c_start;
    write_byte(8'h73, ack);
    chk("persist_ack", {31'h0, ack}, 1);
    read_tail(1);

    model[3] = 8'h3C;
    model[4] = 8'h4D;
    do_write(8'h03, 2, 24'h3C4D00);
    do_read(4'd3, 2);
    do_read(4'd15, 3);

    // stop after 4 data bits: byte dropped, back to idle
    sq.delete();
    i2c_start;
    write_byte(8'h72, ack);
    write_byte(8'h05, ack);
    send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1);
    i2c_stop;
    wclk(3);
    chk("abort_strobes", sq.size(), 0);
    chk("abort_busy", {31'h0, busy}, 0);
    chk("abort_oe", {31'h0, sda_padoen_o}, 1);
    peek(4'd5, model[5]);
    scl = 1'b0;
    wclk(5);
    write_byte(8'h72, ack);
    chk("abort_idle_noack", {31'h0, ack}, 0);
    i2c_stop;

    // reset asserted while the slave drives ACK
    i2c_start;
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : (8'h72 >> i) & 1'b1);
    wclk(8);
    chk("ack_driven", {31'h0, sda_padoen_o}, 0);
    chk("ack_busy", {31'h0, busy}, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release_oe", {31'h0, sda_padoen_o}, 1);
    wclk(3);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    ptr_m = 4'd0;
    scl = 1'b1;
    wclk(10);
    scl = 1'b0;
    i2c_stop;
    for (int i = 0; i < 16; i++) peek(4'(i), 8'h00);

    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(8'($urandom_range(0, 255)), $urandom_range(1, 3),
                 24'($urandom));
      else
        do_read(4'($urandom_range(0, 15)), $urandom_range(1, 3));
    end

    for (int i = 0; i < 16; i++) peek(4'(i), model[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 8'h72, giving the 8-bit write-form slave address; bit 0 is ignored when matching.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all logic is synchronous to its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port scl_pad_i, input, 1 bit: raw I2C SCL line.
REQ-005 The block SHALL have port sda_pad_i, input, 1 bit: raw I2C SDA line.
REQ-006 The block SHALL have port sda_pad_o, output, 1 bit: SDA drive value, constant 1'b0.
REQ-007 The block SHALL have port sda_padoen_o, output, 1 bit: SDA output enable, active-low (0 pulls SDA low).
REQ-008 The block SHALL have port busy, output, 1 bit: high from an address-matched START until the next STOP or return to IDLE.
REQ-009 The block SHALL have port wr_strobe, output, 1 bit: one-clk pulse per register written from the bus.
REQ-010 The block SHALL have port wr_addr, output, 4 bits: register index of the current wr_strobe.
REQ-011 The block SHALL have port wr_data, output, 8 bits: data of the current wr_strobe.
REQ-012 The block SHALL have port rd_addr, input, 4 bits: local read index.
REQ-013 The block SHALL have port rd_data, output, 8 bits: reg[rd_addr], combinational.

Function
REQ-014 SCL and SDA SHALL each pass through a 2-flop synchronizer; edge detection SHALL use the synchronized values. Required clk rate: at least 20x SCL.
REQ-015 START SHALL be detected as synchronized SDA falling while synchronized SCL is high; STOP as SDA rising while SCL is high.
REQ-016 START, including repeated START, SHALL enter DEV_ADDR from any state, clear the bit counter, and release SDA.
REQ-017 STOP SHALL enter IDLE from any state and release SDA.
REQ-018 States SHALL be IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA and RD_ACK.
REQ-019 Bits SHALL be sampled MSB-first on the SCL rising edge; SDA drive changes SHALL occur only on the clk after an SCL falling edge.
REQ-020 After 8 address bits, if bits[7:1] equal DEV_ADDR[7:1], the block SHALL drive ACK (sda_padoen_o=0) during the 9th SCL clock and set busy. Otherwise it SHALL return to IDLE without ACK.
REQ-021 After a matched ACK, R/W=0 SHALL lead to REG_ADDR. R/W=1 SHALL lead to RD_DATA, loading the shift register with reg[ptr].
REQ-022 In REG_ADDR, the received byte's bits [3:0] SHALL load ptr, bits [7:4] SHALL be ignored, and the block SHALL ACK.
REQ-023 Each byte received in WR_DATA SHALL be written to reg[ptr] and ACKed. On the clk the 8th bit is sampled, the block SHALL pulse wr_strobe with wr_addr=ptr and wr_data=byte, then set ptr=ptr+1 mod 16.
REQ-024 In RD_DATA, the block SHALL drive each bit, releasing SDA for 1s, then release SDA for the master ACK bit (RD_ACK) and increment ptr mod 16.
REQ-025 A master ACK (SDA=0) SHALL reload the shift register with the new reg[ptr] and continue. A master NACK SHALL release SDA and wait in IDLE for STOP or START.
REQ-026 The ACK drive SHALL be released on the clk after the SCL falling edge that ends the 9th clock.
REQ-027 ptr wraps 15->0 for both reads and writes. ptr SHALL persist across transactions, so a write of REG_ADDR followed by a repeated-START read begins at that index.
REQ-028 When a STOP or START arrives mid-byte, the partial byte SHALL be discarded and no write SHALL occur.

Reset
REQ-029 While rst_n=0 at a clk edge, the block SHALL set: state=IDLE, sda_padoen_o=1, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, ptr=0, all 16 registers=8'h00, and synchronizers=1.
REQ-030 Reset asserted mid-transfer SHALL release SDA on the same edge. After rst_n rises, the block SHALL ignore the bus until the next START.

Verification
REQ-031 Scenario: START, 0x72, 0x08, 0x35, STOP -> three ACKs; one wr_strobe with wr_addr=8, wr_data=0x35; rd_addr=8 gives rd_data=0x35.
REQ-032 Scenario: START, 0x7A, STOP -> no ACK (SDA stays high on 9th clock), busy stays 0, no wr_strobe.
REQ-033 Scenario: write 0x0F then data 0xA1, 0xB2 -> reg[15]=0xA1, reg[0]=0xB2 (wrap).
REQ-034 Scenario: START, 0x72, 0x03, repeated START, 0x73, read 2 bytes (ACK, then NACK), STOP -> returns reg[3] then reg[4]; SDA released after NACK.
REQ-035 Scenario: STOP injected after 4 data bits of a write -> no wr_strobe, state IDLE, SDA released.
REQ-036 Scenario: rst_n low during slave ACK -> sda_padoen_o=1 on that clk; all registers read 0x00.
